// File: rtl/fround_pkg.sv
// fround_lanes shared types: rounding mode encodings and
// width helpers for the requantizer lanes.
package fround_pkg;

  typedef enum logic [1:0] {
    RND_FLOOR     = 2'b00,
    RND_HALF_UP   = 2'b01,
    RND_HALF_EVEN = 2'b10,
    RND_HALF_AWAY = 2'b11
  } rnd_mode_e;

  function automatic int f_extra(
    input int in_frac,
    input int out_frac
  );
    return in_frac - out_frac;
  endfunction

  function automatic longint f_max(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint f_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/fround_lane.sv
// One requantizer lane: round-increment decode ahead of S1,
// add/saturate/flags between S1 and S2. Purely combinational.
module fround_lane
  import fround_pkg::*;
#(
  parameter int INWIDTH  = 33,
  parameter int IN_FRAC  = 26,
  parameter int OUTWIDTH = 16,
  parameter int OUT_FRAC = 13,
  localparam int EXTRA = f_extra(IN_FRAC, OUT_FRAC),
  localparam int QW    = INWIDTH - EXTRA
) (
  input  logic [INWIDTH-1:0]  i_din,
  input  rnd_mode_e           i_mode,
  output logic [QW-1:0]       o_q,
  output logic                o_inc,
  output logic                o_nz,
  input  logic [QW-1:0]       i_q,
  input  logic                i_inc,
  input  logic                i_nz,
  output logic [OUTWIDTH-1:0] o_dout,
  output logic                o_sat,
  output logic                o_ovf,
  output logic                o_udf
);

  localparam int RW = QW + 1;
  localparam logic signed [RW-1:0] MAXV =
    RW'(f_max(OUTWIDTH));
  localparam logic signed [RW-1:0] MINV =
    RW'(f_min(OUTWIDTH));

  logic w_s;
  logic w_l;
  logic w_g;
  logic w_t;
  logic signed [RW-1:0] w_r;

  assign w_s  = i_din[INWIDTH-1];
  assign w_l  = i_din[EXTRA];
  assign w_g  = i_din[EXTRA-1];
  assign o_q  = i_din[INWIDTH-1:EXTRA];
  assign o_nz = |i_din;

  generate
    if (EXTRA > 1) begin : g_t
      assign w_t = |i_din[EXTRA-2:0];
    end else begin : g_no_t
      assign w_t = 1'b0;
    end
  endgenerate

  always_comb begin
    o_inc = 1'b0;
    unique case (i_mode)
      RND_FLOOR:     o_inc = 1'b0;
      RND_HALF_UP:   o_inc = w_g;
      RND_HALF_EVEN: o_inc = w_g & (w_t | w_l);
      RND_HALF_AWAY: o_inc = w_g & (~w_s | w_t);
    endcase
  end

  // one guard bit so q+inc can never wrap
  assign w_r = $signed({i_q[QW-1], i_q})
             + $signed({{(RW-1){1'b0}}, i_inc});

  always_comb begin
    o_dout = w_r[OUTWIDTH-1:0];
    o_sat  = 1'b0;
    o_ovf  = 1'b0;
    if (w_r > MAXV) begin
      o_dout = MAXV[OUTWIDTH-1:0];
      o_sat  = 1'b1;
      o_ovf  = 1'b1;
    end else if (w_r < MINV) begin
      o_dout = MINV[OUTWIDTH-1:0];
      o_sat  = 1'b1;
    end
  end

  assign o_udf = i_nz && (w_r == '0);

endmodule

// File: rtl/fround_lanes.sv
// Multi-lane two-stage elastic requantizer with saturation flags.
// Define FROUND_STATS_EN to build the SAT/UDF beat counters.
module fround_lanes
  import fround_pkg::*;
#(
  parameter int LANES    = 4,
  parameter int INWIDTH  = 33,
  parameter int IN_FRAC  = 26,
  parameter int OUTWIDTH = 16,
  parameter int OUT_FRAC = 13,
  parameter int CNT_W    = 16
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [1:0]                MODE,
  input  logic                      IN_VALID,
  output logic                      IN_READY,
  input  logic [LANES*INWIDTH-1:0]  DIN,
  output logic                      OUT_VALID,
  input  logic                      OUT_READY,
  output logic [LANES*OUTWIDTH-1:0] DOUT,
  output logic [LANES-1:0]          SATUR,
  output logic [LANES-1:0]          OVFL,
  output logic [LANES-1:0]          UDFL,
  input  logic                      CLR_STAT,
  output logic [CNT_W-1:0]          SAT_CNT,
  output logic [CNT_W-1:0]          UDF_CNT
);

  localparam int EXTRA = f_extra(IN_FRAC, OUT_FRAC);
  localparam int QW    = INWIDTH - EXTRA;

  logic w_s1_adv;
  logic w_s2_adv;
  logic w_acc;
  logic r_s1_valid;
  logic r_s2_valid;

  logic [QW-1:0]    w_q [LANES];
  logic [LANES-1:0] w_inc;
  logic [LANES-1:0] w_nz;
  logic [QW-1:0]    r_s1_q [LANES];
  logic [LANES-1:0] r_s1_inc;
  logic [LANES-1:0] r_s1_nz;

  logic [LANES*OUTWIDTH-1:0] w_dout;
  logic [LANES-1:0]          w_sat;
  logic [LANES-1:0]          w_ovf;
  logic [LANES-1:0]          w_udf;
  logic [LANES*OUTWIDTH-1:0] r_dout;
  logic [LANES-1:0]          r_sat;
  logic [LANES-1:0]          r_ovf;
  logic [LANES-1:0]          r_udf;

  assign w_s2_adv = !r_s2_valid || OUT_READY;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign IN_READY = !RESET && w_s1_adv;
  assign w_acc    = IN_VALID && IN_READY;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    fround_lane #(
      .INWIDTH  (INWIDTH),
      .IN_FRAC  (IN_FRAC),
      .OUTWIDTH (OUTWIDTH),
      .OUT_FRAC (OUT_FRAC)
    ) u_lane (
      .i_din  (DIN[i*INWIDTH +: INWIDTH]),
      .i_mode (rnd_mode_e'(MODE)),
      .o_q    (w_q[i]),
      .o_inc  (w_inc[i]),
      .o_nz   (w_nz[i]),
      .i_q    (r_s1_q[i]),
      .i_inc  (r_s1_inc[i]),
      .i_nz   (r_s1_nz[i]),
      .o_dout (w_dout[i*OUTWIDTH +: OUTWIDTH]),
      .o_sat  (w_sat[i]),
      .o_ovf  (w_ovf[i]),
      .o_udf  (w_udf[i])
    );
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_s1_valid <= 1'b0;
      r_s1_inc   <= '0;
      r_s1_nz    <= '0;
      for (int i = 0; i < LANES; i++) begin
        r_s1_q[i] <= '0;
      end
    end else if (w_s1_adv) begin
      r_s1_valid <= w_acc;
      if (w_acc) begin
        r_s1_inc <= w_inc;
        r_s1_nz  <= w_nz;
        for (int i = 0; i < LANES; i++) begin
          r_s1_q[i] <= w_q[i];
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_s2_valid <= 1'b0;
      r_dout     <= '0;
      r_sat      <= '0;
      r_ovf      <= '0;
      r_udf      <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_dout <= w_dout;
        r_sat  <= w_sat;
        r_ovf  <= w_ovf;
        r_udf  <= w_udf;
      end
    end
  end

  assign OUT_VALID = r_s2_valid;
  assign DOUT      = r_dout;
  assign SATUR     = r_sat;
  assign OVFL      = r_ovf;
  assign UDFL      = r_udf;

`ifdef FROUND_STATS_EN
  logic             w_fire;
  logic [CNT_W-1:0] r_sat_cnt;
  logic [CNT_W-1:0] r_udf_cnt;

  assign w_fire = r_s2_valid && OUT_READY;

  // clear beats a same-cycle increment; counts stick at all-ones
  always_ff @(posedge CLK) begin
    if (RESET || CLR_STAT) begin
      r_sat_cnt <= '0;
      r_udf_cnt <= '0;
    end else if (w_fire) begin
      if (|r_sat && !(&r_sat_cnt)) begin
        r_sat_cnt <= r_sat_cnt + CNT_W'(1);
      end
      if (|r_udf && !(&r_udf_cnt)) begin
        r_udf_cnt <= r_udf_cnt + CNT_W'(1);
      end
    end
  end

  assign SAT_CNT = r_sat_cnt;
  assign UDF_CNT = r_udf_cnt;
`else
  logic w_unused_clr;
  assign w_unused_clr = CLR_STAT;
  assign SAT_CNT = '0;
  assign UDF_CNT = '0;
`endif

endmodule

// File: tb/tb_fround_lanes.sv
// Randomised bench for fround_lanes against a behavioural
// rounding model and a beat queue with 2-deep capacity.
`timescale 1ns/1ps
module tb_fround_lanes;

  localparam int L  = 4;
  localparam int IW = 33;
  localparam int OW = 16;
  localparam int EX = 13;
  localparam longint ONE  = longint'(1) <<< EX;
  localparam longint HALF = longint'(1) <<< (EX - 1);
  localparam longint OMAX = 32767;
  localparam longint OMIN = -32768;
`ifdef FROUND_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic [1:0] MODE = 2'b00;
  logic IN_VALID = 1'b0;
  logic OUT_READY = 1'b0;
  logic CLR_STAT = 1'b0;
  logic [L*IW-1:0] DIN = '0;

  logic IN_READY, OUT_VALID;
  logic [L*OW-1:0] DOUT;
  logic [L-1:0] SATUR, OVFL, UDFL;
  logic [15:0] SAT_CNT, UDF_CNT;

  logic IN_READY2, OUT_VALID2;
  logic [L*OW-1:0] DOUT2;
  logic [L-1:0] SATUR2, OVFL2, UDFL2;
  logic [1:0] SAT_CNT2, UDF_CNT2;

  always #5 CLK = ~CLK;

  fround_lanes #(.CNT_W(16)) u_dut (
    .CLK(CLK), .RESET(RESET), .MODE(MODE),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .DIN(DIN), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .DOUT(DOUT),
    .SATUR(SATUR), .OVFL(OVFL), .UDFL(UDFL),
    .CLR_STAT(CLR_STAT),
    .SAT_CNT(SAT_CNT), .UDF_CNT(UDF_CNT)
  );

  fround_lanes #(.CNT_W(2)) u_dut2 (
    .CLK(CLK), .RESET(RESET), .MODE(MODE),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY2),
    .DIN(DIN), .OUT_VALID(OUT_VALID2),
    .OUT_READY(OUT_READY), .DOUT(DOUT2),
    .SATUR(SATUR2), .OVFL(OVFL2), .UDFL(UDFL2),
    .CLR_STAT(CLR_STAT),
    .SAT_CNT(SAT_CNT2), .UDF_CNT(UDF_CNT2)
  );

  typedef struct {
    logic [L*OW-1:0] dout;
    logic [L-1:0] sat;
    logic [L-1:0] ovf;
    logic [L-1:0] udf;
    int e;
  } beat_t;

  beat_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int edge_n = 0;
  bit rst_seen = 0;
  bit last_rst = 0;
  longint sat16 = 0, udf16 = 0, sat2 = 0, udf2 = 0;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic void ref_lane(
    input longint x, input int mode,
    output longint v, output bit s,
    output bit o, output bit u);
    longint fl, rem, r;
    bit inc;
    if (x >= 0) fl = x / ONE;
    else fl = -((-x + ONE - 1) / ONE);
    rem = x - fl * ONE;
    case (mode)
      0: inc = 0;
      1: inc = rem >= HALF;
      2: inc = rem > HALF ||
               (rem == HALF && (fl % 2) != 0);
      default: inc = rem > HALF ||
                     (rem == HALF && x >= 0);
    endcase
    r = fl + longint'(inc);
    s = 0;
    o = 0;
    v = r;
    if (r > OMAX) begin
      v = OMAX; s = 1; o = 1;
    end else if (r < OMIN) begin
      v = OMIN; s = 1;
    end
    u = (x != 0) && (r == 0);
  endfunction

  function automatic beat_t ref_beat(
    input logic [L*IW-1:0] d, input logic [1:0] m);
    beat_t b;
    longint x, v;
    bit s, o, u;
    b.e = 0;
    for (int i = 0; i < L; i++) begin
      x = longint'($signed(d[i*IW +: IW]));
      ref_lane(x, int'(m), v, s, o, u);
      b.dout[i*OW +: OW] = v[OW-1:0];
      b.sat[i] = s;
      b.ovf[i] = o;
      b.udf[i] = u;
    end
    return b;
  endfunction

  function automatic bit mdl_valid();
    return q.size() > 0 && (edge_n - q[0].e) >= 1;
  endfunction

  function automatic longint bump(
    input longint c, input longint top);
    return (c >= top) ? c : c + 1;
  endfunction

  task automatic pin(input string nm, input longint x,
                     input int m, input longint ev,
                     input bit es, input bit eo,
                     input bit eu);
    longint v;
    bit s, o, u;
    ref_lane(x, m, v, s, o, u);
    chk(nm, {v[15:0], s, o, u},
        {ev[15:0], es, eo, eu});
  endtask

  task automatic cyc();
    bit er, acc, fire, rst, clr;
    logic [L*IW-1:0] d;
    logic [1:0] m;
    beat_t b;
    bit ev;
    #1;
    er = !RESET && (q.size() < 2 || OUT_READY);
    chk("in_ready", {IN_READY, IN_READY2}, {er, er});
    acc = IN_VALID && er;
    fire = mdl_valid() && OUT_READY;
    rst = RESET;
    clr = CLR_STAT;
    d = DIN;
    m = MODE;
    @(posedge CLK);
    edge_n++;
    if (rst) begin
      q.delete();
      sat16 = 0; udf16 = 0; sat2 = 0; udf2 = 0;
      rst_seen = 1;
    end else begin
      if (fire) begin
        b = q.pop_front();
        if (|b.sat) begin
          sat16 = bump(sat16, 65535);
          sat2 = bump(sat2, 3);
        end
        if (|b.udf) begin
          udf16 = bump(udf16, 65535);
          udf2 = bump(udf2, 3);
        end
      end
      if (clr) begin
        sat16 = 0; udf16 = 0; sat2 = 0; udf2 = 0;
      end
      if (acc) begin
        b = ref_beat(d, m);
        b.e = edge_n;
        q.push_back(b);
      end
    end
    last_rst = rst;
    @(negedge CLK);
    if (rst_seen) begin
      ev = mdl_valid();
      chk("out_valid", OUT_VALID, ev);
      if (ev) begin
        chk("dout", DOUT, q[0].dout);
        chk("flags", {SATUR, OVFL, UDFL},
            {q[0].sat, q[0].ovf, q[0].udf});
        chk("dut2", {OUT_VALID2, DOUT2, SATUR2, OVFL2, UDFL2},
            {1'b1, q[0].dout, q[0].sat, q[0].ovf, q[0].udf});
      end else begin
        chk("dut2_valid", OUT_VALID2, 1'b0);
      end
      if (last_rst) begin
        chk("rst_zero", {OUT_VALID, DOUT, SATUR, OVFL, UDFL},
            '0);
      end
      chk("cnt16", {SAT_CNT, UDF_CNT},
          STATS ? {sat16[15:0], udf16[15:0]} : 32'd0);
      chk("cnt2", {SAT_CNT2, UDF_CNT2},
          STATS ? {sat2[1:0], udf2[1:0]} : 4'd0);
    end
  endtask

  function automatic logic [IW-1:0] rnd_word();
    longint x;
    bit neg;
    neg = $urandom_range(0, 1) == 1;
    case ($urandom_range(0, 4))
      0: x = longint'($signed(IW'({$urandom(), $urandom()})));
      1: x = longint'($urandom_range(0, 40000)) - 20000;
      2: x = (longint'($urandom_range(0, 16)) + 32760) * ONE
           + longint'($urandom_range(0, 8191));
      3: x = (longint'($urandom_range(0, 200)) - 100) * ONE
           + HALF;
      default: x = longint'($urandom_range(0, 8191));
    endcase
    if (neg) x = -x;
    return x[IW-1:0];
  endfunction

  task automatic rnd_din(input longint lane0);
    for (int i = 1; i < L; i++) DIN[i*IW +: IW] = rnd_word();
    DIN[IW-1:0] = lane0[IW-1:0];
  endtask

  task automatic idle(input int n);
    IN_VALID = 0;
    OUT_READY = 1;
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic push(input longint x, input int m);
    rnd_din(x);
    MODE = m[1:0];
    IN_VALID = 1;
    OUT_READY = 1;
    cyc();
    IN_VALID = 0;
  endtask

  longint dx[14] = '{20480, 20480, 20480, 20480,
                     -20480, -20480, -20480, -20480,
                     (32767 <<< 13) + 4096, -(40000 <<< 13),
                     4095, -4096, -4096, 0};
  int dm[14] = '{0, 1, 2, 3, 0, 1, 2, 3, 1, 0, 1, 1, 3, 1};

  initial begin
    int n0;
    longint sv;

    pin("m_floor_p", 20480, 0, 2, 0, 0, 0);
    pin("m_up_p", 20480, 1, 3, 0, 0, 0);
    pin("m_even_p", 20480, 2, 2, 0, 0, 0);
    pin("m_away_p", 20480, 3, 3, 0, 0, 0);
    pin("m_floor_n", -20480, 0, -3, 0, 0, 0);
    pin("m_up_n", -20480, 1, -2, 0, 0, 0);
    pin("m_even_n", -20480, 2, -2, 0, 0, 0);
    pin("m_away_n", -20480, 3, -3, 0, 0, 0);
    pin("m_ovfl", (32767 <<< 13) + 4096, 1,
        32767, 1, 1, 0);
    pin("m_neg_sat", -(40000 <<< 13), 0,
        -32768, 1, 0, 0);
    pin("m_udf_p", 4095, 1, 0, 0, 0, 1);
    pin("m_udf_n", -4096, 1, 0, 0, 0, 1);
    pin("m_away_m1", -4096, 3, -1, 0, 0, 0);
    pin("m_zero", 0, 1, 0, 0, 0, 0);

    RESET = 1;
    for (int i = 0; i < 3; i++) cyc();
    RESET = 0;
    idle(1);

    push(20480, 1);
    chk("lat_c1", OUT_VALID, 1'b0);
    idle(1);
    chk("lat_c2", OUT_VALID, 1'b1);
    chk("lat_dout", DOUT[15:0], 16'd3);
    idle(2);

    for (int i = 0; i < 14; i++) begin
      push(dx[i], dm[i]);
      if (i % 3 == 0) idle(1);
    end
    idle(4);

    n0 = q.size();
    OUT_READY = 0;
    IN_VALID = 1;
    for (int i = 0; i < 5; i++) begin
      rnd_din(longint'($signed(rnd_word())));
      MODE = 2'($urandom_range(0, 3));
      cyc();
    end
    chk("bp_acc", 32'(q.size() - n0), 32'd2);
    #1;
    chk("bp_ready", IN_READY, 1'b0);
    IN_VALID = 0;
    idle(4);

    CLR_STAT = 1;
    idle(1);
    CLR_STAT = 0;
    for (int i = 0; i < 3; i++) push(-(40000 <<< 13), 0);
    idle(3);
    chk("sat3", SAT_CNT, STATS ? 16'd3 : 16'd0);
    chk("sat3_w2", SAT_CNT2, STATS ? 2'd3 : 2'd0);
    OUT_READY = 0;
    rnd_din(-(40000 <<< 13));
    IN_VALID = 1;
    cyc();
    IN_VALID = 0;
    cyc();
    OUT_READY = 1;
    CLR_STAT = 1;
    cyc();
    CLR_STAT = 0;
    chk("clr_wins", SAT_CNT, 16'd0);
    for (int i = 0; i < 5; i++) push((40000 <<< 13), 2);
    idle(3);
    chk("sat5", SAT_CNT, STATS ? 16'd5 : 16'd0);
    chk("sat5_w2", SAT_CNT2, STATS ? 2'd3 : 2'd0);

    OUT_READY = 0;
    IN_VALID = 1;
    for (int i = 0; i < 2; i++) begin
      rnd_din(20480);
      cyc();
    end
    IN_VALID = 0;
    RESET = 1;
    cyc();
    chk("rst_ov", OUT_VALID, 1'b0);
    RESET = 0;
    idle(4);

    for (int c = 0; c < 3000; c++) begin
      IN_VALID = $urandom_range(0, 9) < 7;
      OUT_READY = $urandom_range(0, 9) < 7;
      MODE = 2'($urandom_range(0, 3));
      CLR_STAT = $urandom_range(0, 99) < 3;
      RESET = $urandom_range(0, 199) == 0;
      sv = longint'($signed(rnd_word()));
      rnd_din(sv);
      cyc();
    end
    RESET = 0;
    CLR_STAT = 0;
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
